// File: rtl/data_cache.sv
// Direct-mapped, write-through, write-no-allocate data cache in front of main_memory.
// Read hits return combinationally; misses refill a full 4-word line over the block port.
`timescale 1ns/1ps
module data_cache #(
  parameter int add_width  = 10,
  parameter int data_width = 32,
  parameter int num_lines  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [add_width-1:0]    cpu_add,
  input  logic                    cpu_read,
  input  logic                    cpu_write,
  input  logic [data_width-1:0]   cpu_write_data,
  output logic [data_width-1:0]   cpu_read_data,
  output logic                    stall,
  output logic [add_width-1:0]    mem_add,
  output logic [data_width-1:0]   mem_write_data,
  output logic                    mem_read,
  output logic                    mem_write,
  input  logic [4*data_width-1:0] mem_read_data,
  input  logic                    ready_to_read,
  input  logic                    finished_writing
);
  localparam int IDX_W  = $clog2(num_lines);
  localparam int TAG_W  = add_width - IDX_W - 2;
  localparam int LINE_W = 4 * data_width;

  typedef enum logic [2:0] {IDLE, RD_MEM, RD_FILL, WR_MEM, WR_DONE} state_t;

  state_t                state_q;
  logic [1:0]            beat_q;
  logic [num_lines-1:0]  valid_q;
  logic [TAG_W-1:0]      tag_q  [num_lines];
  logic [LINE_W-1:0]     line_q [num_lines];
  logic [add_width-1:0]  req_add_q;
  logic [data_width-1:0] req_data_q;
  logic                  mem_read_q;
  logic                  mem_write_q;

  logic [1:0]            cpu_off;
  logic [IDX_W-1:0]      cpu_idx;
  logic [TAG_W-1:0]      cpu_tag;
  logic [1:0]            req_off;
  logic [IDX_W-1:0]      req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic                  cpu_hit;
  logic                  req_hit;
  logic [data_width-1:0] rd_word;

  assign cpu_off = cpu_add[1:0];
  assign cpu_idx = cpu_add[IDX_W+1:2];
  assign cpu_tag = cpu_add[add_width-1:IDX_W+2];
  assign req_off = req_add_q[1:0];
  assign req_idx = req_add_q[IDX_W+1:2];
  assign req_tag = req_add_q[add_width-1:IDX_W+2];

  assign cpu_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign mem_add        = req_add_q;
  assign mem_write_data = req_data_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;

  always_comb begin
    rd_word = '0;
    for (int w = 0; w < 4; w++) begin
      if (cpu_off == w[1:0]) rd_word = line_q[cpu_idx][w*data_width +: data_width];
    end
  end

  // A store holds the CPU until the memory confirms it; a read only stalls on a miss.
  always_comb begin
    stall         = 1'b1;
    cpu_read_data = '0;
    case (state_q)
      IDLE: begin
        if (cpu_write) begin
          stall = 1'b1;
        end else if (cpu_read) begin
          stall = !cpu_hit;
          if (cpu_hit) cpu_read_data = rd_word;
        end else begin
          stall = 1'b0;
        end
      end
      WR_DONE: stall = !finished_writing;
      default: stall = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= 2'd0;
      valid_q     <= '0;
      req_add_q   <= '0;
      req_data_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          beat_q <= 2'd0;
          if (cpu_write) begin
            req_add_q   <= cpu_add;
            req_data_q  <= cpu_write_data;
            mem_write_q <= 1'b1;
            state_q     <= WR_MEM;
          end else if (cpu_read && !cpu_hit) begin
            req_add_q  <= {cpu_add[add_width-1:2], 2'b00};
            mem_read_q <= 1'b1;
            state_q    <= RD_MEM;
          end
        end
        RD_MEM: begin
          beat_q <= beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            mem_read_q <= 1'b0;
            state_q    <= RD_FILL;
          end
        end
        RD_FILL: begin
          beat_q <= 2'd0;
          if (ready_to_read) begin
            valid_q[req_idx] <= 1'b1;
            state_q          <= IDLE;
          end else begin
            // Memory counter out of step: replay the full 4-cycle strobe.
            mem_read_q <= 1'b1;
            state_q    <= RD_MEM;
          end
        end
        WR_MEM: begin
          beat_q <= beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            mem_write_q <= 1'b0;
            state_q     <= WR_DONE;
          end
        end
        WR_DONE: begin
          beat_q <= 2'd0;
          if (finished_writing) begin
            state_q <= IDLE;
          end else begin
            mem_write_q <= 1'b1;
            state_q     <= WR_MEM;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line data and tags carry no reset; valid bits alone decide whether they are used.
  always_ff @(posedge clk) begin
    if (state_q == RD_FILL && ready_to_read) begin
      tag_q[req_idx]  <= req_tag;
      line_q[req_idx] <= mem_read_data;
    end else if (state_q == WR_DONE && finished_writing && req_hit) begin
      for (int w = 0; w < 4; w++) begin
        if (req_off == w[1:0]) line_q[req_idx][w*data_width +: data_width] <= req_data_q;
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: a fixed-latency memory responder, a line-level cache model
// driving per-cycle expectations, and one negedge compare process.
`timescale 1ns/1ps
module tb_data_cache;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [9:0]   cpu_add;
  logic         cpu_read;
  logic         cpu_write;
  logic [31:0]  cpu_write_data;
  logic [31:0]  cpu_read_data;
  logic         stall;
  logic [9:0]   mem_add;
  logic [31:0]  mem_write_data;
  logic         mem_read;
  logic         mem_write;
  logic [127:0] mem_read_data = '0;
  logic         ready_to_read = 1'b0;
  logic         finished_writing = 1'b0;

  data_cache #(.add_width(10), .data_width(32), .num_lines(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_add(cpu_add), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data), .stall(stall),
    .mem_add(mem_add), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_read_data(mem_read_data), .ready_to_read(ready_to_read),
    .finished_writing(finished_writing)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Memory contents seen by the responder, and the reference copy the model owns.
  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic        drop_ready = 1'b0;

  // Model of the cache contents: which index holds which tag.
  bit   [15:0] m_valid = '0;
  logic [3:0]  m_tag [16];

  // Per-cycle expectations consumed by the compare process.
  logic        exp_on = 1'b0;
  logic        exp_stall, exp_mrd, exp_mwr, exp_add_chk, exp_wd_chk;
  logic [31:0] exp_rdata, exp_wd;
  logic [9:0]  exp_add;
  logic        lit_on = 1'b0;
  logic [31:0] lit_val = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", nm, act, want, $time);
    end
  endtask

  // Memory: 4 consecutive strobe cycles complete an access; flags stay until the next access.
  always @(posedge clk) begin
    if (mem_read) begin
      if (rd_cnt == 3) begin
        rd_cnt <= 0;
        ready_to_read <= !drop_ready;
        for (int k = 0; k < 4; k++) mem_read_data[k*32 +: 32] <= mem[{mem_add[9:2], k[1:0]}];
      end else begin
        rd_cnt <= rd_cnt + 1;
        ready_to_read <= 1'b0;
      end
    end else begin
      rd_cnt <= 0;
    end
    if (mem_write) begin
      if (wr_cnt == 3) begin
        wr_cnt <= 0;
        mem[mem_add] = mem_write_data;
        finished_writing <= 1'b1;
      end else begin
        wr_cnt <= wr_cnt + 1;
        finished_writing <= 1'b0;
      end
    end else begin
      wr_cnt <= 0;
    end
  end

  always @(negedge clk) begin
    if (exp_on) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("cpu_read_data", cpu_read_data, exp_rdata);
      chk("mem_read", 32'(mem_read), 32'(exp_mrd));
      chk("mem_write", 32'(mem_write), 32'(exp_mwr));
      if (exp_add_chk) chk("mem_add", 32'(mem_add), 32'(exp_add));
      if (exp_wd_chk) chk("mem_write_data", mem_write_data, exp_wd);
      if (lit_on) chk("literal_rdata", cpu_read_data, lit_val);
    end
  end

  task automatic cyc(input logic s, input logic [31:0] rd, input logic mr, input logic mw,
                     input logic ac, input logic wc);
    exp_on = 1'b1; exp_stall = s; exp_rdata = rd; exp_mrd = mr; exp_mwr = mw;
    exp_add_chk = ac; exp_wd_chk = wc;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    cpu_read = 1'b0; cpu_write = 1'b0;
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_read(input logic [9:0] a, input bit drop, input bit use_lit, input logic [31:0] lit);
    int idx;
    idx = int'(a[5:2]);
    cpu_add = a; cpu_read = 1'b1; cpu_write = 1'b0;
    if (m_valid[idx] && m_tag[idx] == a[9:6]) begin
      lit_on = use_lit; lit_val = lit;
      cyc(1'b0, ref_mem[a], 1'b0, 1'b0, 1'b0, 1'b0);
      lit_on = 1'b0;
    end else begin
      exp_add = {a[9:2], 2'b00};
      drop_ready = drop;
      cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int r = 0; r < (drop ? 2 : 1); r++) begin
        for (int b = 0; b < 4; b++) cyc(1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        drop_ready = 1'b0;
      end
      m_valid[idx] = 1'b1;
      m_tag[idx] = a[9:6];
      lit_on = use_lit; lit_val = lit;
      cyc(1'b0, ref_mem[a], 1'b0, 1'b0, 1'b0, 1'b0);
      lit_on = 1'b0;
    end
    cpu_read = 1'b0;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input bit also_read);
    cpu_add = a; cpu_write = 1'b1; cpu_read = also_read; cpu_write_data = d;
    exp_add = a; exp_wd = d;
    cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++) cyc(1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    ref_mem[a] = d;
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    cpu_write = 1'b0; cpu_read = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'hC0DE0000 | i;
      ref_mem[i] = 32'hC0DE0000 | i;
    end
    rst_n = 1'b0; cpu_add = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_write_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_rdata", cpu_read_data, 32'h0);
    chk("rst_mem_read", 32'(mem_read), 32'h0);
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_mem_add", 32'(mem_add), 32'h0);
    chk("rst_mem_wdata", mem_write_data, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    idle(1);

    do_read(10'h045, 1'b0, 1'b1, 32'hC0DE0045);      // cold miss, refill from 0x044
    do_read(10'h046, 1'b0, 1'b1, 32'hC0DE0046);      // hit in the new line
    do_write(10'h045, 32'hDEADBEEF, 1'b0);          // write hit
    do_read(10'h045, 1'b0, 1'b1, 32'hDEADBEEF);
    idle(1);
    do_write(10'h1C0, 32'h12345678, 1'b0);          // write miss, no allocation
    do_read(10'h1C0, 1'b0, 1'b1, 32'h12345678);
    do_read(10'h085, 1'b0, 1'b1, 32'hC0DE0085);      // evicts index 1
    do_read(10'h045, 1'b0, 1'b1, 32'hDEADBEEF);      // misses again
    do_read(10'h046, 1'b0, 1'b0, 32'h0);
    do_write(10'h047, 32'hA5A55A5A, 1'b1);          // store wins over a simultaneous load
    do_read(10'h047, 1'b0, 1'b1, 32'hA5A55A5A);
    do_read(10'h2F3, 1'b1, 1'b1, 32'hC0DE02F3);      // first refill attempt dropped
    idle(2);

    // Reset in the second RD_MEM cycle of a miss.
    cpu_add = 10'h385; cpu_read = 1'b1;
    exp_add = 10'h384;
    cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_on = 1'b0;
    #2 rst_n = 1'b0; cpu_read = 1'b0;
    #1;
    chk("async_rst_mem_read", 32'(mem_read), 32'h0);
    chk("async_rst_stall", 32'(stall), 32'h0);
    chk("async_rst_mem_add", 32'(mem_add), 32'h0);
    m_valid = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    idle(2);
    do_read(10'h045, 1'b0, 1'b1, 32'hDEADBEEF);
    idle(1);
    exp_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
